// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Contents:
//   requester_t  - identifies the core or host port (arbitration winner, response owner)
//   rsp_src_t    - where a registered read response takes its data from
//   req_bundle_t - one requester's access fields gathered into a single bus
package dmem_arb_pkg;

  // Bus address width and the widest data word the request bundle carries.
  // dmem_arbiter's p_WORD_LEN must not exceed BUS_WORD_LEN.
  localparam int unsigned BUS_ADDR_LEN = 16;
  localparam int unsigned BUS_WORD_LEN = 16;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_HOST = 1'b1
  } requester_t;

  typedef enum logic [1:0] {
    RSP_MEM  = 2'd0,
    RSP_DISP = 2'd1,
    RSP_ZERO = 2'd2
  } rsp_src_t;

  typedef struct packed {
    logic                    req;
    logic                    wr_en;
    logic [BUS_ADDR_LEN-1:0] addr;
    logic [BUS_WORD_LEN-1:0] wr_data;
  } req_bundle_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter shared by the core and host memory ports.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; also suppresses all grants while high
//   req  - request vector, bit REQ_CORE = core, bit REQ_HOST = host
//   gnt  - one-hot grant, combinational from req and the last winner
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  requester_t r_last;

  // Under contention the requester that did not win last time goes first,
  // so a held request waits at most one cycle.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (r_last == REQ_HOST) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset to HOST so the core wins the first contention after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= REQ_HOST;
    end else if (gnt[0]) begin
      r_last <= REQ_CORE;
    end else if (gnt[1]) begin
      r_last <= REQ_HOST;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous data memory (1-cycle read latency) between
// the core data port and the host/debug port, and decodes the 16-bit address
// space: in-range words go to memory, p_DISPLAY_ADDR is the display register,
// every other address reads 0 and drops writes.
// Ports:
//   i_clk, i_rst                 - clock, synchronous active-high reset
//   i_core_* / o_core_*          - core request fields, grant, read response
//   i_host_* / o_host_*          - host request fields, grant, read response
//   o_mem_addr/_wr_en/_wr_data   - memory command, same cycle as the grant
//   i_mem_rd_data                - memory read data, the cycle after the address
//   o_display                    - display register contents
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned p_WORD_LEN     = 16,
  parameter int unsigned p_ADDR_LEN     = 10,
  parameter logic [15:0] p_DISPLAY_ADDR = 16'hFFFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_core_req,
  input  logic                  i_core_wr_en,
  input  logic [15:0]           i_core_addr,
  input  logic [p_WORD_LEN-1:0] i_core_wr_data,
  output logic                  o_core_gnt,
  output logic                  o_core_rd_valid,
  output logic [p_WORD_LEN-1:0] o_core_rd_data,
  input  logic                  i_host_req,
  input  logic                  i_host_wr_en,
  input  logic [15:0]           i_host_addr,
  input  logic [p_WORD_LEN-1:0] i_host_wr_data,
  output logic                  o_host_gnt,
  output logic                  o_host_rd_valid,
  output logic [p_WORD_LEN-1:0] o_host_rd_data,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic                  o_mem_wr_en,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
  output logic [p_WORD_LEN-1:0] o_display
);

  req_bundle_t core_bus;
  req_bundle_t host_bus;
  logic [1:0]  gnt;
  logic        any_gnt;

  logic                    win_wr_en;
  logic [BUS_ADDR_LEN-1:0] win_addr;
  logic [BUS_WORD_LEN-1:0] win_data;
  logic                    win_in_range;
  logic                    win_is_disp;

  logic [p_ADDR_LEN-1:0] r_hold_addr;
  logic [p_WORD_LEN-1:0] r_hold_data;
  logic [p_WORD_LEN-1:0] r_display;
  logic                  r_rsp_valid;
  requester_t            r_rsp_owner;
  rsp_src_t              r_rsp_src;
  logic [p_WORD_LEN-1:0] rsp_data;
  logic                  rsp_live;

  assign core_bus = '{req: i_core_req, wr_en: i_core_wr_en, addr: i_core_addr,
                      wr_data: BUS_WORD_LEN'(i_core_wr_data)};
  assign host_bus = '{req: i_host_req, wr_en: i_host_wr_en, addr: i_host_addr,
                      wr_data: BUS_WORD_LEN'(i_host_wr_data)};

  rr_arb2 u_arb (
    .clk (i_clk),
    .rst (i_rst),
    .req ({host_bus.req, core_bus.req}),
    .gnt (gnt)
  );

  assign any_gnt    = |gnt;
  assign o_core_gnt = gnt[0];
  assign o_host_gnt = gnt[1];

  // Winner select and address decode. Only meaningful while any_gnt is high.
  always_comb begin
    win_wr_en = core_bus.wr_en;
    win_addr  = core_bus.addr;
    win_data  = core_bus.wr_data;
    if (gnt[1]) begin
      win_wr_en = host_bus.wr_en;
      win_addr  = host_bus.addr;
      win_data  = host_bus.wr_data;
    end
    win_in_range = ((win_addr >> p_ADDR_LEN) == '0);
    win_is_disp  = (win_addr == p_DISPLAY_ADDR);
  end

  // Memory command; with no grant the address and data stay at the last
  // granted values so the memory inputs do not toggle needlessly.
  assign o_mem_wr_en   = any_gnt & win_wr_en & win_in_range;
  assign o_mem_addr    = any_gnt ? win_addr[p_ADDR_LEN-1:0] : r_hold_addr;
  assign o_mem_wr_data = any_gnt ? p_WORD_LEN'(win_data) : r_hold_data;

  // Display register, response pipeline stage and held memory command.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_display   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= REQ_CORE;
      r_rsp_src   <= RSP_ZERO;
      r_hold_addr <= '0;
      r_hold_data <= '0;
    end else begin
      r_rsp_valid <= any_gnt & ~win_wr_en;
      r_rsp_owner <= gnt[1] ? REQ_HOST : REQ_CORE;
      if (win_in_range) begin
        r_rsp_src <= RSP_MEM;
      end else if (win_is_disp) begin
        r_rsp_src <= RSP_DISP;
      end else begin
        r_rsp_src <= RSP_ZERO;
      end
      if (any_gnt & win_wr_en & win_is_disp) begin
        r_display <= p_WORD_LEN'(win_data);
      end
      if (any_gnt) begin
        r_hold_addr <= win_addr[p_ADDR_LEN-1:0];
        r_hold_data <= p_WORD_LEN'(win_data);
      end
    end
  end

  // Response data source. r_display here is still the pre-write value when a
  // display write is granted in the same cycle as the response.
  always_comb begin
    case (r_rsp_src)
      RSP_MEM:  rsp_data = i_mem_rd_data;
      RSP_DISP: rsp_data = r_display;
      default:  rsp_data = '0;
    endcase
  end

  // A response pending when reset arrives is dropped immediately.
  assign rsp_live        = r_rsp_valid & ~i_rst;
  assign o_core_rd_valid = rsp_live & (r_rsp_owner == REQ_CORE);
  assign o_host_rd_valid = rsp_live & (r_rsp_owner == REQ_HOST);
  assign o_core_rd_data  = o_core_rd_valid ? rsp_data : '0;
  assign o_host_rd_data  = o_host_rd_valid ? rsp_data : '0;
  assign o_display       = r_display;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 1-cycle-latency
// single-port memory attached to the memory port.
module tb_dmem_arbiter;

  localparam int WL = 16;
  localparam int AL = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_wr_en, host_req, host_wr_en;
  logic [15:0]   core_addr, host_addr;
  logic [WL-1:0] core_wr_data, host_wr_data;
  logic          core_gnt, core_rd_valid, host_gnt, host_rd_valid;
  logic [WL-1:0] core_rd_data, host_rd_data;
  logic [AL-1:0] mem_addr;
  logic          mem_wr_en;
  logic [WL-1:0] mem_wr_data, mem_rd_data, display;

  logic [WL-1:0] mem_model [0:(1<<AL)-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Synchronous single-port memory: write commits at the edge, read data
  // appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_wr_en) mem_model[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem_model[mem_addr];
  end

  dmem_arbiter #(
    .p_WORD_LEN     (WL),
    .p_ADDR_LEN     (AL),
    .p_DISPLAY_ADDR (16'hFFFF)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_core_req      (core_req),
    .i_core_wr_en    (core_wr_en),
    .i_core_addr     (core_addr),
    .i_core_wr_data  (core_wr_data),
    .o_core_gnt      (core_gnt),
    .o_core_rd_valid (core_rd_valid),
    .o_core_rd_data  (core_rd_data),
    .i_host_req      (host_req),
    .i_host_wr_en    (host_wr_en),
    .i_host_addr     (host_addr),
    .i_host_wr_data  (host_wr_data),
    .o_host_gnt      (host_gnt),
    .o_host_rd_valid (host_rd_valid),
    .o_host_rd_data  (host_rd_data),
    .o_mem_addr      (mem_addr),
    .o_mem_wr_en     (mem_wr_en),
    .o_mem_wr_data   (mem_wr_data),
    .i_mem_rd_data   (mem_rd_data),
    .o_display       (display)
  );

  // Drive one cycle's inputs just after the rising edge, then leave time for
  // the combinational outputs to settle before the checks that follow.
  task automatic applyStimulus(input logic r,
                               input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                               input logic hr, input logic hw, input logic [15:0] ha, input logic [15:0] hd);
    @(posedge clk);
    #1;
    rst          = r;
    core_req     = cr;
    core_wr_en   = cw;
    core_addr    = ca;
    core_wr_data = cd;
    host_req     = hr;
    host_wr_en   = hw;
    host_addr    = ha;
    host_wr_data = hd;
    #3;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    core_req = 0; core_wr_en = 0; core_addr = 0; core_wr_data = 0;
    host_req = 0; host_wr_en = 0; host_addr = 0; host_wr_data = 0;

    // Reset with both requesting: grants suppressed, outputs cleared.
    applyStimulus(1, 1, 0, 16'd1, 16'd0, 1, 0, 16'd2, 16'd0);
    applyStimulus(1, 1, 0, 16'd1, 16'd0, 1, 0, 16'd2, 16'd0);
    checkOutput("rst_core_gnt", core_gnt, 0);
    checkOutput("rst_host_gnt", host_gnt, 0);
    checkOutput("rst_mem_wr_en", mem_wr_en, 0);
    checkOutput("rst_core_rd_valid", core_rd_valid, 0);
    checkOutput("rst_host_rd_valid", host_rd_valid, 0);
    checkOutput("rst_display", display, 16'h0000);

    // Core write 1234 to addr 5, then read it back.
    applyStimulus(0, 1, 1, 16'd5, 16'h1234, 0, 0, 16'd0, 16'd0);
    checkOutput("t1_wr_core_gnt", core_gnt, 1);
    checkOutput("t1_wr_host_gnt", host_gnt, 0);
    checkOutput("t1_wr_mem_wr_en", mem_wr_en, 1);
    checkOutput("t1_wr_mem_addr", 16'(mem_addr), 16'd5);
    checkOutput("t1_wr_mem_data", mem_wr_data, 16'h1234);
    applyStimulus(0, 1, 0, 16'd5, 16'h0000, 0, 0, 16'd0, 16'd0);
    checkOutput("t1_rd_core_gnt", core_gnt, 1);
    checkOutput("t1_rd_mem_wr_en", mem_wr_en, 0);
    checkOutput("t1_no_valid_after_wr", core_rd_valid, 0);
    applyStimulus(0, 0, 0, 16'd0, 16'h0000, 0, 0, 16'd0, 16'd0);
    checkOutput("t1_core_rd_valid", core_rd_valid, 1);
    checkOutput("t1_core_rd_data", core_rd_data, 16'h1234);
    checkOutput("t1_host_rd_valid", host_rd_valid, 0);
    checkOutput("t1_host_rd_data", host_rd_data, 16'h0000);
    checkOutput("t1_idle_gnt", core_gnt, 0);
    checkOutput("t1_idle_wr_en", mem_wr_en, 0);
    checkOutput("t1_idle_addr_held", 16'(mem_addr), 16'd5);

    // Preload words 0, 1 and 2 through the host port.
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 1, 1, 16'd1, 16'h0011);
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 1, 1, 16'd2, 16'h0022);
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 1, 1, 16'd0, 16'h0000);

    // Contention from reset: core first, then alternating.
    applyStimulus(1, 0, 0, 16'd0, 16'h0, 0, 0, 16'd0, 16'h0);
    applyStimulus(0, 1, 0, 16'd1, 16'h0, 1, 0, 16'd2, 16'h0);
    checkOutput("t2_c0_core_gnt", core_gnt, 1);
    checkOutput("t2_c0_host_gnt", host_gnt, 0);
    checkOutput("t2_c0_mem_addr", 16'(mem_addr), 16'd1);
    applyStimulus(0, 1, 0, 16'd1, 16'h0, 1, 0, 16'd2, 16'h0);
    checkOutput("t2_c1_host_gnt", host_gnt, 1);
    checkOutput("t2_c1_core_gnt", core_gnt, 0);
    checkOutput("t2_c1_mem_addr", 16'(mem_addr), 16'd2);
    checkOutput("t2_c1_core_rd_valid", core_rd_valid, 1);
    checkOutput("t2_c1_core_rd_data", core_rd_data, 16'h0011);
    checkOutput("t2_c1_host_rd_valid", host_rd_valid, 0);
    applyStimulus(0, 1, 0, 16'd1, 16'h0, 1, 0, 16'd2, 16'h0);
    checkOutput("t2_c2_core_gnt", core_gnt, 1);
    checkOutput("t2_c2_host_rd_valid", host_rd_valid, 1);
    checkOutput("t2_c2_host_rd_data", host_rd_data, 16'h0022);
    checkOutput("t2_c2_core_rd_valid", core_rd_valid, 0);
    checkOutput("t2_c2_core_rd_data", core_rd_data, 16'h0000);
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 0, 0, 16'd0, 16'h0);
    checkOutput("t2_c3_core_rd_valid", core_rd_valid, 1);
    checkOutput("t2_c3_core_rd_data", core_rd_data, 16'h0011);

    // Host writes the display register, core reads it back.
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 1, 1, 16'hFFFF, 16'hBEEF);
    checkOutput("t3_wr_host_gnt", host_gnt, 1);
    checkOutput("t3_wr_mem_wr_en", mem_wr_en, 0);
    applyStimulus(0, 1, 0, 16'hFFFF, 16'h0, 0, 0, 16'd0, 16'h0);
    checkOutput("t3_display", display, 16'hBEEF);
    checkOutput("t3_rd_core_gnt", core_gnt, 1);
    checkOutput("t3_rd_mem_wr_en", mem_wr_en, 0);
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 1, 1, 16'hFFFF, 16'h1111);
    checkOutput("t3_core_rd_valid", core_rd_valid, 1);
    checkOutput("t3_core_rd_data_old", core_rd_data, 16'hBEEF);
    checkOutput("t3_wr2_host_gnt", host_gnt, 1);
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 0, 0, 16'd0, 16'h0);
    checkOutput("t3_display_new", display, 16'h1111);

    // Out-of-range write is granted but dropped; read returns zero.
    applyStimulus(0, 1, 1, 16'h0800, 16'h5555, 0, 0, 16'd0, 16'h0);
    checkOutput("t4_wr_core_gnt", core_gnt, 1);
    checkOutput("t4_wr_mem_wr_en", mem_wr_en, 0);
    applyStimulus(0, 1, 0, 16'h0800, 16'h0, 0, 0, 16'd0, 16'h0);
    checkOutput("t4_rd_core_gnt", core_gnt, 1);
    applyStimulus(0, 1, 0, 16'h0000, 16'h0, 0, 0, 16'd0, 16'h0);
    checkOutput("t4_oor_rd_valid", core_rd_valid, 1);
    checkOutput("t4_oor_rd_data", core_rd_data, 16'h0000);
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 0, 0, 16'd0, 16'h0);
    checkOutput("t4_mem0_rd_valid", core_rd_valid, 1);
    checkOutput("t4_mem0_unchanged", core_rd_data, 16'h0000);
    checkOutput("t4_display_kept", display, 16'h1111);

    // Core write to 7 then host read of 7 on the next cycle.
    applyStimulus(0, 1, 1, 16'd7, 16'h00AA, 0, 0, 16'd0, 16'h0);
    checkOutput("t6_wr_mem_wr_en", mem_wr_en, 1);
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 1, 0, 16'd7, 16'h0);
    checkOutput("t6_rd_host_gnt", host_gnt, 1);
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 0, 0, 16'd0, 16'h0);
    checkOutput("t6_host_rd_valid", host_rd_valid, 1);
    checkOutput("t6_host_rd_data", host_rd_data, 16'h00AA);
    checkOutput("t6_core_rd_valid", core_rd_valid, 0);

    // Host read granted, reset in the following cycle drops the response.
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 1, 0, 16'd2, 16'h0);
    checkOutput("t5_host_gnt", host_gnt, 1);
    applyStimulus(1, 1, 0, 16'd1, 16'h0, 1, 0, 16'd2, 16'h0);
    checkOutput("t5_rst_host_rd_valid", host_rd_valid, 0);
    checkOutput("t5_rst_core_gnt", core_gnt, 0);
    checkOutput("t5_rst_host_gnt", host_gnt, 0);
    applyStimulus(0, 1, 0, 16'd1, 16'h0, 1, 0, 16'd2, 16'h0);
    checkOutput("t5_post_host_rd_valid", host_rd_valid, 0);
    checkOutput("t5_post_display", display, 16'h0000);
    checkOutput("t5_post_core_gnt", core_gnt, 1);
    checkOutput("t5_post_host_gnt", host_gnt, 0);
    applyStimulus(0, 0, 0, 16'd0, 16'h0, 0, 0, 16'd0, 16'h0);
    checkOutput("t5_core_rd_valid", core_rd_valid, 1);
    checkOutput("t5_core_rd_data", core_rd_data, 16'h0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (1-cycle read latency) between the core data port and a host/debug port (loader, trace reader).
- Decodes the 16-bit address space: in-range words go to memory; p_DISPLAY_ADDR is a readable/writable display register; all other addresses read 0 and drop writes.
- Sits between the core, the host bridge and mem_data at top level.
- Replaces the ad-hoc display latch and out-of-range read masking in the top level.

Parameters:
- p_WORD_LEN, 16, data word width.
- p_ADDR_LEN, 10, memory address width; memory holds 2**p_ADDR_LEN words.
- p_DISPLAY_ADDR, 16'hFFFF, address of the display register.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_core_req  in  1  core access request; held with stable fields until granted.
- i_core_wr_en  in  1  1 = write, 0 = read.
- i_core_addr  in  16  word address.
- i_core_wr_data  in  p_WORD_LEN  write data.
- o_core_gnt  out  1  access accepted this cycle (combinational).
- o_core_rd_valid  out  1  read data valid; one cycle after a granted read.
- o_core_rd_data  out  p_WORD_LEN  read data.
- i_host_req, i_host_wr_en, i_host_addr, i_host_wr_data  in  1/1/16/p_WORD_LEN  same meaning as the core port.
- o_host_gnt, o_host_rd_valid, o_host_rd_data  out  1/1/p_WORD_LEN  same meaning as the core port.
- o_mem_addr  out  p_ADDR_LEN  memory address.
- o_mem_wr_en  out  1  memory write strobe.
- o_mem_wr_data  out  p_WORD_LEN  memory write data.
- i_mem_rd_data  in  p_WORD_LEN  memory read data, valid the cycle after the address.
- o_display  out  p_WORD_LEN  display register contents.

Behaviour:
- Arbitration: at most one grant per cycle, decided combinationally from the requests and r_last.
  - Only one requester active: that requester is granted.
  - Both active: the requester not equal to r_last is granted.
  - r_last updates to the winner on every grant.
  - Reset sets r_last = HOST, so the core wins the first contention.
- Starvation bound: a requester that is held waits at most 1 cycle.
- Grant-to-memory routing (same cycle as the grant):
  - o_mem_addr = winner addr[p_ADDR_LEN-1:0].
  - o_mem_wr_data = winner write data.
  - o_mem_wr_en = gnt & wr_en & (addr < 2**p_ADDR_LEN).
  - With no grant: o_mem_wr_en = 0; addr and data are don't-care but held at the last value.
- Display register:
  - A granted write with addr == p_DISPLAY_ADDR loads r_display at the clock edge.
  - Writes to any other out-of-range address are granted and discarded.
- Read response:
  - A granted read registers the response owner (CORE/HOST) and the source: MEM if in range, DISP if addr == p_DISPLAY_ADDR, else ZERO.
  - Next cycle, the owner's rd_valid = 1 for exactly one cycle.
  - rd_data = i_mem_rd_data for MEM, r_display for DISP (the value before any write in that same cycle), 0 for ZERO.
  - The non-owner's rd_valid = 0. rd_data of any port with rd_valid = 0 is driven to 0.
- Back-to-back: a grant is allowed every cycle. Responses pipeline, one per cycle, in grant order.
- Ordering: a read granted the cycle after a write to the same address returns the new data, because memory commits the write at the edge.
- Writes produce no rd_valid.
- Reset (including mid-operation):
  - Next cycle: o_core_rd_valid = o_host_rd_valid = 0, rd_data = 0, o_display = 0, o_mem_wr_en = 0.
  - Any pending response is dropped.
  - Grants are suppressed while i_rst = 1.
- Latency: grant in cycle 0, write commit at the end of cycle 0, read data in cycle 1.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum requester_t {REQ_CORE, REQ_HOST}.
  - typedef enum rsp_src_t {RSP_MEM, RSP_DISP, RSP_ZERO}.
  - Struct for a request bundle (req, wr_en, addr, wr_data).
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0].
  - Outputs: gnt[1:0] one-hot.
  - Holds the r_last register, with the same reset rule as above.
- The top of dmem_arbiter does the address decode, response pipeline and display register.

Test Plan:
- Core only, write 16'h1234 to addr 5, then read addr 5 -> o_core_gnt=1 both cycles; o_mem_wr_en=1 in cycle 0; o_core_rd_valid=1 in cycle 2 with 16'h1234; host signals stay 0.
- Both request reads every cycle from reset (core addr 1, host addr 2) -> grants alternate core, host, core, ...; each rd_valid pulses on alternate cycles with the matching mem data; neither port waits more than 1 cycle.
- Host writes 16'hBEEF to 16'hFFFF, then core reads 16'hFFFF -> o_display=16'hBEEF the cycle after the write; core reads 16'hBEEF; o_mem_wr_en stays 0.
- Core writes 16'h5555 to 16'h0800 (out of range), then reads it -> granted; o_mem_wr_en=0; read returns 0 with rd_valid=1; memory contents unchanged.
- Host read granted, i_rst asserted in the following cycle -> no host rd_valid; o_display=0; the first post-reset contention grants the core.
- Core write to addr 7 (16'h00AA) in cycle n, host read of addr 7 in cycle n+1 -> host receives 16'h00AA in cycle n+2.
